// File: rtl/if_fetch_queue_pkg.sv
// if_fetch_queue_pkg: shared constants and types for the fetch queue.
// NOP encoding, enable levels, fetch-entry layout, saturating helper.
package if_fetch_queue_pkg;

    localparam logic [31:0] ISA_NOP = 32'h0000_0013;

    localparam logic EN  = 1'b1;
    localparam logic DIS = 1'b0;

    typedef struct packed {
        logic [29:0] pc;
        logic [31:0] insn;
        logic        filled;
    } fetch_entry_t;

    function automatic logic [31:0] sat_inc32(input logic [31:0] v);
        return (&v) ? v : v + 32'd1;
    endfunction

endpackage

// File: rtl/if_fetch_slots.sv
// if_fetch_slots: DEPTH-entry fetch buffer with alloc/fill/read pointers.
// Tracks occupancy (allocated - released) and pending (allocated - filled).
module if_fetch_slots
    import if_fetch_queue_pkg::*;
#(
    parameter int unsigned ADDR_W = 30,
    parameter int unsigned INSN_W = 32,
    parameter int unsigned DEPTH  = 4,
    parameter int unsigned CNT_W  = $clog2(DEPTH) + 1
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              clear,
    input  logic              alloc_en,
    input  logic [ADDR_W-1:0] alloc_pc,
    input  logic              fill_en,
    input  logic [INSN_W-1:0] fill_insn,
    input  logic              rd_en,
    output logic [CNT_W-1:0]  occupancy,
    output logic [CNT_W-1:0]  pending,
    output logic              head_valid,
    output logic [ADDR_W-1:0] head_pc,
    output logic [INSN_W-1:0] head_insn
);

    localparam int unsigned PTR_W = $clog2(DEPTH);

    typedef struct packed {
        logic [ADDR_W-1:0] pc;
        logic [INSN_W-1:0] insn;
        logic              filled;
    } slot_t;

    slot_t             slots [DEPTH];
    logic [PTR_W-1:0]  alloc_ptr;
    logic [PTR_W-1:0]  fill_ptr;
    logic [PTR_W-1:0]  rd_ptr;

    // Allocate on grant, fill on response, release on ID accept.
    always_ff @(posedge clk) begin
        if (reset) begin
            alloc_ptr <= '0;
            fill_ptr  <= '0;
            rd_ptr    <= '0;
            occupancy <= '0;
            pending   <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                slots[i] <= '0;
            end
        end else if (clear) begin
            alloc_ptr <= '0;
            fill_ptr  <= '0;
            rd_ptr    <= '0;
            occupancy <= '0;
            pending   <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                slots[i].filled <= 1'b0;
            end
        end else begin
            if (alloc_en) begin
                slots[alloc_ptr].pc <= alloc_pc;
                alloc_ptr <= alloc_ptr + 1'b1;
            end
            if (fill_en) begin
                slots[fill_ptr].insn   <= fill_insn;
                slots[fill_ptr].filled <= 1'b1;
                fill_ptr <= fill_ptr + 1'b1;
            end
            if (rd_en) begin
                slots[rd_ptr].filled <= 1'b0;
                rd_ptr <= rd_ptr + 1'b1;
            end
            occupancy <= occupancy + CNT_W'(alloc_en) - CNT_W'(rd_en);
            pending   <= pending + CNT_W'(alloc_en) - CNT_W'(fill_en);
        end
    end

    assign head_valid = slots[rd_ptr].filled;
    assign head_pc    = slots[rd_ptr].pc;
    assign head_insn  = slots[rd_ptr].insn;

endmodule

// File: rtl/if_fetch_queue.sv
// if_fetch_queue: fetch PC owner, imem requester and ID-side queue.
// Optional IF_FETCH_PERF_EN adds stall/redirect/drop counters.
module if_fetch_queue
    import if_fetch_queue_pkg::*;
#(
    parameter int unsigned       ADDR_W   = 30,
    parameter int unsigned       INSN_W   = 32,
    parameter int unsigned       DEPTH    = 4,
    parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              flush,
    input  logic [ADDR_W-1:0] new_pc,
    input  logic              br_taken,
    input  logic [ADDR_W-1:0] br_addr,
    output logic              imem_req,
    output logic [ADDR_W-1:0] imem_addr,
    input  logic              imem_gnt,
    input  logic              imem_rvalid,
    input  logic [INSN_W-1:0] imem_rdata,
    input  logic              id_ready,
    output logic              id_valid,
    output logic [ADDR_W-1:0] id_pc,
    output logic [INSN_W-1:0] id_insn
`ifdef IF_FETCH_PERF_EN
    ,
    output logic [31:0]       perf_stall_cyc,
    output logic [31:0]       perf_redirects,
    output logic [31:0]       perf_dropped
`endif
);

    localparam int unsigned CNT_W  = $clog2(DEPTH) + 1;
    localparam int unsigned DROP_W = CNT_W + 4;
    localparam logic [INSN_W-1:0] NOP = INSN_W'(ISA_NOP);

    logic [ADDR_W-1:0] fetch_pc;
    logic [DROP_W-1:0] drop_cnt;
    logic [CNT_W-1:0]  occupancy;
    logic [CNT_W-1:0]  pending;
    logic              redirect;
    logic [ADDR_W-1:0] target;
    logic              grant;
    logic              drop_rsp;
    logic              fill_rsp;
    logic              accept;
    logic              head_valid;
    logic [ADDR_W-1:0] head_pc;
    logic [INSN_W-1:0] head_insn;

    assign redirect  = flush | br_taken;
    assign target    = flush ? new_pc : br_addr;
    assign imem_req  = ~reset & ~redirect & (occupancy < CNT_W'(DEPTH));
    assign imem_addr = fetch_pc;
    assign grant     = imem_req & imem_gnt;
    assign drop_rsp  = imem_rvalid & (drop_cnt != '0);
    assign fill_rsp  = imem_rvalid & (drop_cnt == '0);
    assign accept    = head_valid & id_ready;

    assign id_valid = head_valid;
    assign id_pc    = head_pc;
    assign id_insn  = head_valid ? head_insn : NOP;

    if_fetch_slots #(
        .ADDR_W (ADDR_W),
        .INSN_W (INSN_W),
        .DEPTH  (DEPTH),
        .CNT_W  (CNT_W)
    ) u_slots (
        .clk        (clk),
        .reset      (reset),
        .clear      (redirect),
        .alloc_en   (grant),
        .alloc_pc   (fetch_pc),
        .fill_en    (fill_rsp),
        .fill_insn  (imem_rdata),
        .rd_en      (accept),
        .occupancy  (occupancy),
        .pending    (pending),
        .head_valid (head_valid),
        .head_pc    (head_pc),
        .head_insn  (head_insn)
    );

    // Fetch PC: redirect target wins, else advance on each grant.
    always_ff @(posedge clk) begin
        if (reset) begin
            fetch_pc <= RESET_PC;
        end else if (redirect) begin
            fetch_pc <= target;
        end else if (grant) begin
            fetch_pc <= fetch_pc + 1'b1;
        end
    end

    // Responses owed to squashed requests; a response this cycle
    // settles either an old drop or one of the pending requests.
    always_ff @(posedge clk) begin
        if (reset) begin
            drop_cnt <= '0;
        end else if (redirect) begin
            drop_cnt <= drop_cnt - DROP_W'(drop_rsp)
                      + DROP_W'(pending) - DROP_W'(fill_rsp);
        end else if (drop_rsp) begin
            drop_cnt <= drop_cnt - 1'b1;
        end
    end

    a_rsp_owed : assert property (
        @(posedge clk) disable iff (reset)
        imem_rvalid |-> (drop_cnt != '0 || pending != '0)
    );

`ifdef IF_FETCH_PERF_EN
    // Saturating event counters for stalls, redirects and drops.
    always_ff @(posedge clk) begin
        if (reset) begin
            perf_stall_cyc <= '0;
            perf_redirects <= '0;
            perf_dropped   <= '0;
        end else begin
            if (!head_valid && !redirect) begin
                perf_stall_cyc <= sat_inc32(perf_stall_cyc);
            end
            if (redirect) begin
                perf_redirects <= sat_inc32(perf_redirects);
            end
            if (drop_rsp) begin
                perf_dropped <= sat_inc32(perf_dropped);
            end
        end
    end
`endif

endmodule

// File: tb/tb_if_fetch_queue.sv
// tb_if_fetch_queue: directed checks for if_fetch_queue.
// In-order memory model with 1-cycle latency and a hold control.
module tb_if_fetch_queue;
    import if_fetch_queue_pkg::*;

    localparam int AW    = 30;
    localparam int IW    = 32;
    localparam int DEPTH = 4;
    localparam logic [AW-1:0] RPC = 30'h100;

    logic          clk = 1'b0;
    logic          reset;
    logic          flush;
    logic [AW-1:0] new_pc;
    logic          br_taken;
    logic [AW-1:0] br_addr;
    logic          imem_req;
    logic [AW-1:0] imem_addr;
    logic          imem_gnt;
    logic          imem_rvalid;
    logic [IW-1:0] imem_rdata;
    logic          id_ready;
    logic          id_valid;
    logic [AW-1:0] id_pc;
    logic [IW-1:0] id_insn;
`ifdef IF_FETCH_PERF_EN
    logic [31:0]   perf_stall_cyc;
    logic [31:0]   perf_redirects;
    logic [31:0]   perf_dropped;
`endif

    int n_vec = 0;
    int n_bad = 0;

    logic          s_req;
    logic          s_valid;
    logic [AW-1:0] s_addr;
    logic [AW-1:0] s_pc;
    logic [IW-1:0] s_insn;
    logic          mem_hold;
    logic [AW-1:0] mem_q [$];

    always #5 clk = ~clk;

    if_fetch_queue #(
        .ADDR_W   (AW),
        .INSN_W   (IW),
        .DEPTH    (DEPTH),
        .RESET_PC (RPC)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .flush       (flush),
        .new_pc      (new_pc),
        .br_taken    (br_taken),
        .br_addr     (br_addr),
        .imem_req    (imem_req),
        .imem_addr   (imem_addr),
        .imem_gnt    (imem_gnt),
        .imem_rvalid (imem_rvalid),
        .imem_rdata  (imem_rdata),
        .id_ready    (id_ready),
        .id_valid    (id_valid),
        .id_pc       (id_pc),
        .id_insn     (id_insn)
`ifdef IF_FETCH_PERF_EN
        ,
        .perf_stall_cyc (perf_stall_cyc),
        .perf_redirects (perf_redirects),
        .perf_dropped   (perf_dropped)
`endif
    );

    function automatic logic [IW-1:0] insn_of(input logic [AW-1:0] a);
        return {a, 2'b11} ^ 32'h5A00_0000;
    endfunction

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h want %h", tag, got, exp);
        end
    endtask

    // Called at a negedge with inputs set: drive response, sample.
    task automatic cyc;
        if (!mem_hold && mem_q.size() > 0) begin
            imem_rvalid = 1'b1;
            imem_rdata  = insn_of(mem_q.pop_front());
        end else begin
            imem_rvalid = 1'b0;
            imem_rdata  = '0;
        end
        #1;
        s_req   = imem_req;
        s_addr  = imem_addr;
        s_valid = id_valid;
        s_pc    = id_pc;
        s_insn  = id_insn;
    endtask

    task automatic nxt;
        if (reset) mem_q.delete();
        else if (s_req && imem_gnt) mem_q.push_back(s_addr);
        @(negedge clk);
    endtask

    task automatic do_reset;
        reset = 1'b1;
        flush = 1'b0;
        br_taken = 1'b0;
        mem_hold = 1'b0;
        cyc; nxt;
        cyc; nxt;
        reset = 1'b0;
    endtask

    // First two requests and first two ID entries must be base, base+1.
    task automatic run_seq(input string tag, input logic [AW-1:0] base,
                           input int maxc);
        int nr = 0;
        int nv = 0;
        logic [AW-1:0] a;
        for (int i = 0; i < maxc; i++) begin
            cyc;
            if (s_req && nr < 2) begin
                a = base + AW'(nr);
                chk({tag, " req addr"}, 32'(s_addr), 32'(a));
                nr++;
            end
            if (s_valid && nv < 2) begin
                a = base + AW'(nv);
                chk({tag, " id_pc"}, 32'(s_pc), 32'(a));
                chk({tag, " id_insn"}, s_insn, insn_of(a));
                nv++;
            end
            nxt;
        end
        chk({tag, " entries seen"}, 32'(nv), 32'd2);
    endtask

    initial begin
        int g;
        logic [AW-1:0] a;
        reset = 1'b1; flush = 1'b0; br_taken = 1'b0;
        new_pc = '0; br_addr = '0;
        imem_gnt = 1'b1; id_ready = 1'b1; mem_hold = 1'b0;
        imem_rvalid = 1'b0; imem_rdata = '0;
        @(negedge clk);

        // reset state and streaming
        cyc; nxt;
        cyc;
        chk("rst req", 32'(s_req), 32'd0);
        chk("rst valid", 32'(s_valid), 32'd0);
        chk("rst insn", s_insn, ISA_NOP);
        chk("rst pc", 32'(s_pc), 32'd0);
        nxt;
        reset = 1'b0;
        for (int i = 0; i < 6; i++) begin
            cyc;
            a = RPC + AW'(i);
            chk("s1 req", 32'(s_req), 32'd1);
            chk("s1 addr", 32'(s_addr), 32'(a));
            if (i >= 2) begin
                a = RPC + AW'(i - 2);
                chk("s1 valid", 32'(s_valid), 32'd1);
                chk("s1 pc", 32'(s_pc), 32'(a));
                chk("s1 insn", s_insn, insn_of(a));
            end else begin
                chk("s1 early valid", 32'(s_valid), 32'd0);
            end
            nxt;
        end

        // ID stalls: fill to DEPTH, hold head, then drain in order
        do_reset;
        id_ready = 1'b0;
        g = 0;
        for (int i = 0; i < 10; i++) begin
            cyc;
            if (s_valid) begin
                chk("s2 hold pc", 32'(s_pc), 32'(RPC));
                chk("s2 hold insn", s_insn, insn_of(RPC));
            end
            if (s_req && imem_gnt) g++;
            nxt;
        end
        chk("s2 grants", 32'(g), 32'd4);
        chk("s2 req at full", 32'(s_req), 32'd0);
        chk("s2 valid held", 32'(s_valid), 32'd1);
        id_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            cyc;
            a = RPC + AW'(i);
            chk("s2 drain valid", 32'(s_valid), 32'd1);
            chk("s2 drain pc", 32'(s_pc), 32'(a));
            chk("s2 drain insn", s_insn, insn_of(a));
            if (i == 0) chk("s2 full waits", 32'(s_req), 32'd0);
            if (i == 1) begin
                chk("s2 resume req", 32'(s_req), 32'd1);
                chk("s2 resume addr", 32'(s_addr), 32'(RPC + AW'(4)));
            end
            nxt;
        end

        // branch with two responses outstanding
        do_reset;
        id_ready = 1'b1;
        mem_hold = 1'b1;
        cyc; nxt;
        cyc; nxt;
        br_taken = 1'b1;
        br_addr = 30'h200;
        cyc;
        chk("s3 req in redirect", 32'(s_req), 32'd0);
        nxt;
        br_taken = 1'b0;
        mem_hold = 1'b0;
        run_seq("s3", 30'h200, 8);
`ifdef IF_FETCH_PERF_EN
        chk("s3 perf_redirects", perf_redirects, 32'd1);
        chk("s3 perf_dropped", perf_dropped, 32'd2);
`endif

        // flush beats branch
        flush = 1'b1; new_pc = 30'h300;
        br_taken = 1'b1; br_addr = 30'h200;
        cyc;
        chk("s4 req in redirect", 32'(s_req), 32'd0);
        nxt;
        flush = 1'b0; br_taken = 1'b0;
        run_seq("s4", 30'h300, 8);

        // PC wraps at the top of the address space
        br_taken = 1'b1; br_addr = 30'h3FFF_FFFF;
        cyc; nxt;
        br_taken = 1'b0;
        run_seq("s5", 30'h3FFF_FFFF, 8);

        // reset with full queue and responses pending
        id_ready = 1'b0;
        mem_hold = 1'b1;
        for (int i = 0; i < 6; i++) begin
            cyc; nxt;
        end
        chk("s6 full", 32'(s_req), 32'd0);
        reset = 1'b1;
        cyc; nxt;
        reset = 1'b0;
        mem_hold = 1'b0;
        cyc;
        chk("s6 valid", 32'(s_valid), 32'd0);
        chk("s6 insn", s_insn, ISA_NOP);
        chk("s6 req", 32'(s_req), 32'd1);
        chk("s6 addr", 32'(s_addr), 32'(RPC));
        nxt;

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule

// File: doc/if_fetch_queue.md
Name: if_fetch_queue

Overview:
- Parametrised successor to the IF/ID pipeline register.
- Owns the fetch PC and issues in-order requests to instruction memory.
- Buffers up to DEPTH fetched instructions, each with its PC, and hands them to ID through a valid/ready handshake.
- Handles flush and branch redirect, including discarding memory responses still in flight when a redirect occurs.

Parameters:
- ADDR_W, 30, word-address width of the PC.
- INSN_W, 32, instruction width.
- DEPTH, 4, queue entries; power of two, at least 2.
- RESET_PC, 0, fetch PC after reset.

Ports:
- clk  in  1  clock
- reset  in  1  synchronous, active-high reset
- flush  in  1  pipeline flush; redirect to new_pc
- new_pc  in  ADDR_W  flush target
- br_taken  in  1  branch redirect to br_addr
- br_addr  in  ADDR_W  branch target
- imem_req  out  1  fetch request valid
- imem_addr  out  ADDR_W  fetch address
- imem_gnt  in  1  memory accepts the request this cycle
- imem_rvalid  in  1  response valid; responses return in request order
- imem_rdata  in  INSN_W  response instruction
- id_ready  in  1  ID accepts an entry this cycle (the inverse of the old stall)
- id_valid  out  1  head entry valid
- id_pc  out  ADDR_W  head entry PC
- id_insn  out  INSN_W  head entry instruction; ISA_NOP when id_valid=0

Behaviour:
- Reset (synchronous, highest priority): fetch_pc=RESET_PC; all pointers and counters 0; id_valid=0; id_insn=ISA_NOP; id_pc=0; imem_req=0.
- Slot allocation: a slot is allocated at request time (alloc_ptr), filled at response (fill_ptr) and released on ID accept (rd_ptr).
  - occupancy = allocated - released, range 0..DEPTH.
  - Each slot stores its PC and a filled bit.
- Request:
  - imem_req=1 when occupancy<DEPTH and no redirect is active this cycle.
  - imem_addr=fetch_pc.
  - On imem_req & imem_gnt: store fetch_pc into the slot at alloc_ptr, increment alloc_ptr, then fetch_pc+1 with wrap modulo 2^ADDR_W.
- Response:
  - If drop_cnt>0: discard the response and decrement drop_cnt.
  - Otherwise: write imem_rdata into the slot at fill_ptr, set its filled bit, increment fill_ptr.
- Output: id_valid = head slot allocated & filled. id_pc and id_insn come directly from the head slot (combinational from storage, no extra latency).
- Handshake: on id_valid & id_ready, clear the filled bit and increment rd_ptr. ID data is held stable while id_valid=1 and id_ready=0.
- Redirect: redirect = flush | br_taken. Target = new_pc if flush, else br_addr (flush wins).
  - Same cycle: fetch_pc <= target.
  - Slots cleared; alloc/fill/rd pointers reset to 0.
  - drop_cnt <= unanswered requests, i.e. requests granted but not yet responded, excluding any response arriving this cycle.
  - imem_req forced to 0 that cycle.
  - id_valid is not suppressed combinationally, but any ID accept in the redirect cycle is ignored (pointers cleared).
  - First request to the target is issued on the next cycle.
- Latency: minimum 2 cycles from request grant to id_valid, given a 1-cycle memory.
  - Back-to-back throughput of 1 instruction/cycle when memory and ID keep up.
- Boundaries:
  - Full (occupancy=DEPTH): no request.
  - Simultaneous accept and grant at full: the request still waits one cycle (occupancy is evaluated on the registered value).
  - Empty: id_valid=0.
  - Response with nothing unanswered is illegal; flagged by an assertion.
  - Pointers are log2(DEPTH) bits and wrap naturally.
  - Redirect while drop_cnt>0 adds the new unanswered requests to the remaining drop_cnt.

Optional Feature:
- Macro: IF_FETCH_PERF_EN.
- When defined, adds three outputs:
  - perf_stall_cyc (32): counts cycles with id_valid=0 and no redirect.
  - perf_redirects (32): counts redirects.
  - perf_dropped (32): counts discarded responses.
  - All cleared on reset; saturate at all-ones.
- When undefined: the ports and counters do not exist, and behaviour is otherwise identical.

Decomposition:
- Shared package: ISA_NOP, enable/disable constants, and a fetch-entry typedef {pc, insn, filled}.
- One natural sub-module, if_fetch_slots: DEPTH-entry storage with alloc/fill/read pointers and an occupancy count.
- The top level holds fetch_pc, drop_cnt, request logic and redirect priority.

Test Plan:
- Reset with RESET_PC=0x100, memory granting every cycle with 1-cycle latency, id_ready=1 -> imem_addr 0x100,0x101,… and id_pc 0x100,0x101 on consecutive cycles, starting 2 cycles after the first grant.
- id_ready=0 for 10 cycles, DEPTH=4 -> exactly 4 grants then imem_req=0; id_pc/id_insn hold at 0x100; releasing drains 0x100..0x103 in order.
- br_taken with br_addr=0x200 while 2 requests are unanswered -> next 2 responses dropped; first id_pc after redirect is 0x200 with its correct instruction.
- flush (new_pc=0x300) and br_taken (br_addr=0x200) in the same cycle -> fetch resumes at 0x300.
- fetch_pc at 2^ADDR_W-1 -> next request address 0; synchronous reset mid-stream with full queue and pending responses -> id_valid=0, id_insn=ISA_NOP next cycle, fetch restarts at RESET_PC.
- With IF_FETCH_PERF_EN: scenario 3 -> perf_redirects=1, perf_dropped=2.
